// File: rtl/sram_access_sequencer_if.sv
// CPU request bus plus SRAM pin bundle shared by sram_access_sequencer and its environment.
// ByteEn exists only when SRAM_BYTE_ACCESS_EN is defined.
interface sram_access_sequencer_if #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int SRAM_ADDR_W = 20
);
    logic                   Req;
    logic                   R_W;
    logic [ADDR_W-1:0]      Addr;
    logic [DATA_W-1:0]      WData;
`ifdef SRAM_BYTE_ACCESS_EN
    logic                   ByteEn;
`endif
    logic [DATA_W-1:0]      RData;
    logic                   Ready;
    logic                   Busy;
    logic [SRAM_ADDR_W-1:0] SRAM_ADDR;
    logic                   SRAM_CE_N;
    logic                   SRAM_OE_N;
    logic                   SRAM_WE_N;
    logic                   SRAM_LB_N;
    logic                   SRAM_UB_N;
    logic [DATA_W-1:0]      SRAM_DQ_Out;
    logic                   SRAM_DQ_OE;
    logic [DATA_W-1:0]      SRAM_DQ_In;

    modport master (
`ifdef SRAM_BYTE_ACCESS_EN
        output ByteEn,
`endif
        output Req, R_W, Addr, WData, SRAM_DQ_In,
        input  RData, Ready, Busy, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N,
        input  SRAM_LB_N, SRAM_UB_N, SRAM_DQ_Out, SRAM_DQ_OE
    );

    modport slave (
`ifdef SRAM_BYTE_ACCESS_EN
        input  ByteEn,
`endif
        input  Req, R_W, Addr, WData, SRAM_DQ_In,
        output RData, Ready, Busy, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N,
        output SRAM_LB_N, SRAM_UB_N, SRAM_DQ_Out, SRAM_DQ_OE
    );
endinterface

// File: rtl/sram_access_sequencer.sv
// Registered request/ready sequencer driving asynchronous SRAM pins through setup, strobe, hold and turnaround.
// Define SRAM_BYTE_ACCESS_EN to add per-access byte-lane selection through ByteEn.
module sram_access_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int SRAM_ADDR_W = 20,
    parameter int WAIT_STATES = 2,
    parameter int TURNAROUND  = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    sram_access_sequencer_if.slave io_bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_ACCESS = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_TURN   = 3'd4;

    localparam int W_EFF   = (WAIT_STATES < 1) ? 1 : WAIT_STATES;
    localparam int T_EFF   = (TURNAROUND < 0) ? 0 : TURNAROUND;
    localparam int CNT_MAX = (W_EFF > T_EFF) ? W_EFF : T_EFF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [2:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_isWrite;
    logic [DATA_W-1:0]      r_rdata;
    logic                   r_ready;
    logic                   r_busy;
    logic [SRAM_ADDR_W-1:0] r_sramAddr;
    logic                   r_ceN;
    logic                   r_oeN;
    logic                   r_weN;
    logic                   r_lbN;
    logic                   r_ubN;
    logic [DATA_W-1:0]      r_dqOut;
    logic                   r_dqOe;

    logic                   w_accept;
    logic                   w_isWrite;
    logic                   w_laneLbN;
    logic                   w_laneUbN;
    logic [SRAM_ADDR_W-1:0] w_pinAddr;
    logic [DATA_W-1:0]      w_pinData;
    logic [DATA_W-1:0]      w_capData;
    logic [2:0]             w_nextState;
    logic [CNT_W-1:0]       w_nextCnt;
    logic [DATA_W-1:0]      w_nextRdata;
    logic                   w_ceN;
    logic                   w_oeN;
    logic                   w_weN;
    logic                   w_lbN;
    logic                   w_ubN;
    logic                   w_dqOe;

    // In IDLE the incoming request decides the first phase, afterwards the latched copy does.
    assign w_accept  = (r_state == ST_IDLE) && io_bus.Req;
    assign w_isWrite = (r_state == ST_IDLE) ? io_bus.R_W : r_isWrite;

`ifdef SRAM_BYTE_ACCESS_EN
    localparam int HALF_W = DATA_W / 2;

    logic r_laneLbN;
    logic r_laneUbN;
    logic w_selLbN;
    logic w_selUbN;

    assign w_selLbN  = io_bus.ByteEn & io_bus.Addr[0];
    assign w_selUbN  = io_bus.ByteEn & ~io_bus.Addr[0];
    assign w_laneLbN = (r_state == ST_IDLE) ? w_selLbN : r_laneLbN;
    assign w_laneUbN = (r_state == ST_IDLE) ? w_selUbN : r_laneUbN;
    assign w_pinAddr = io_bus.ByteEn ? SRAM_ADDR_W'(io_bus.Addr >> 1) : SRAM_ADDR_W'(io_bus.Addr);
    assign w_pinData = io_bus.ByteEn ? {2{io_bus.WData[HALF_W-1:0]}} : io_bus.WData;

    // A single disabled lane strobe identifies a byte read and which half to keep.
    always_comb begin
        w_capData = io_bus.SRAM_DQ_In;
        if (r_laneUbN) begin
            w_capData = {{HALF_W{1'b0}}, io_bus.SRAM_DQ_In[HALF_W-1:0]};
        end else if (r_laneLbN) begin
            w_capData = {{HALF_W{1'b0}}, io_bus.SRAM_DQ_In[DATA_W-1:HALF_W]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_laneLbN <= 1'b0;
            r_laneUbN <= 1'b0;
        end else if (w_accept) begin
            r_laneLbN <= w_selLbN;
            r_laneUbN <= w_selUbN;
        end
    end
`else
    assign w_laneLbN = 1'b0;
    assign w_laneUbN = 1'b0;
    assign w_pinAddr = SRAM_ADDR_W'(io_bus.Addr);
    assign w_pinData = io_bus.WData;
    assign w_capData = io_bus.SRAM_DQ_In;
`endif

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextRdata = r_rdata;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.Req) begin
                    w_nextState = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_nextState = ST_ACCESS;
                w_nextCnt   = CNT_W'(W_EFF - 1);
            end
            ST_ACCESS: begin
                if (r_cnt == '0) begin
                    w_nextState = ST_HOLD;
                    if (!r_isWrite) begin
                        w_nextRdata = w_capData;
                    end
                end else begin
                    w_nextCnt = r_cnt - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (T_EFF == 0) begin
                    w_nextState = ST_IDLE;
                end else begin
                    w_nextState = ST_TURN;
                    w_nextCnt   = CNT_W'(T_EFF - 1);
                end
            end
            ST_TURN: begin
                if (r_cnt == '0) begin
                    w_nextState = ST_IDLE;
                end else begin
                    w_nextCnt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Pin strobes are decoded from the phase being entered so every pin leaves a flop.
    always_comb begin
        w_ceN  = 1'b1;
        w_oeN  = 1'b1;
        w_weN  = 1'b1;
        w_lbN  = 1'b1;
        w_ubN  = 1'b1;
        w_dqOe = 1'b0;
        case (w_nextState)
            ST_SETUP: begin
                w_ceN  = 1'b0;
                w_lbN  = w_laneLbN;
                w_ubN  = w_laneUbN;
                w_oeN  = w_isWrite;
                w_dqOe = w_isWrite;
            end
            ST_ACCESS: begin
                w_ceN  = 1'b0;
                w_lbN  = w_laneLbN;
                w_ubN  = w_laneUbN;
                w_oeN  = w_isWrite;
                w_weN  = !w_isWrite;
                w_dqOe = w_isWrite;
            end
            ST_HOLD: begin
                w_ceN  = 1'b0;
                w_lbN  = w_laneLbN;
                w_ubN  = w_laneUbN;
                w_dqOe = w_isWrite;
            end
            default: begin
                w_ceN = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_isWrite  <= 1'b0;
            r_rdata    <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_sramAddr <= '0;
            r_ceN      <= 1'b1;
            r_oeN      <= 1'b1;
            r_weN      <= 1'b1;
            r_lbN      <= 1'b1;
            r_ubN      <= 1'b1;
            r_dqOut    <= '0;
            r_dqOe     <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            r_rdata <= w_nextRdata;
            r_ready <= (w_nextState == ST_HOLD);
            r_busy  <= (w_nextState != ST_IDLE);
            r_ceN   <= w_ceN;
            r_oeN   <= w_oeN;
            r_weN   <= w_weN;
            r_lbN   <= w_lbN;
            r_ubN   <= w_ubN;
            r_dqOe  <= w_dqOe;
            if (w_accept) begin
                r_isWrite  <= io_bus.R_W;
                r_sramAddr <= w_pinAddr;
                if (io_bus.R_W) begin
                    r_dqOut <= w_pinData;
                end
            end
        end
    end

    assign io_bus.RData       = r_rdata;
    assign io_bus.Ready       = r_ready;
    assign io_bus.Busy        = r_busy;
    assign io_bus.SRAM_ADDR   = r_sramAddr;
    assign io_bus.SRAM_CE_N   = r_ceN;
    assign io_bus.SRAM_OE_N   = r_oeN;
    assign io_bus.SRAM_WE_N   = r_weN;
    assign io_bus.SRAM_LB_N   = r_lbN;
    assign io_bus.SRAM_UB_N   = r_ubN;
    assign io_bus.SRAM_DQ_Out = r_dqOut;
    assign io_bus.SRAM_DQ_OE  = r_dqOe;
endmodule

// File: doc/sram_access_sequencer.md
Name: sram_access_sequencer

Overview:
Parametrised, multi-cycle SRAM access engine between the CPU memory interface and the external asynchronous SRAM pins. It replaces the per-signal pin synchronizers with a single registered request/ready state machine that generates setup, strobe and hold phases, a configurable number of wait states and a bus-turnaround gap. It drives the split data bus for the top-level tristate. Memory-mapped I/O decoding stays outside this block.

Parameters:
ADDR_W, 16, CPU address width; must be <= SRAM_ADDR_W.
DATA_W, 16, data width; must be even.
SRAM_ADDR_W, 20, SRAM address pin width.
WAIT_STATES, 2, strobe-phase length in cycles; values < 1 behave as 1.
TURNAROUND, 1, idle cycles after HOLD before the next accept; 0 allowed.

Ports:
Clk  in  1  system clock, all logic on rising edge.
Reset  in  1  synchronous, active-high.
Req  in  1  access request, sampled only in IDLE.
R_W  in  1  1 = write, 0 = read; latched at accept.
Addr  in  ADDR_W  CPU address; latched at accept.
WData  in  DATA_W  write data; latched at accept.
RData  out  DATA_W  read data register.
Ready  out  1  one-cycle completion pulse.
Busy  out  1  high from the cycle after accept through the last TURN cycle.
SRAM_ADDR  out  SRAM_ADDR_W  pin address.
SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N  out  1 each  active-low pin strobes.
SRAM_DQ_Out  out  DATA_W  data to the tristate.
SRAM_DQ_OE  out  1  tristate drive enable.
SRAM_DQ_In  in  DATA_W  data from the tristate.

Behaviour:
- Every output is a flop output; no combinational path from any input to any pin.
- Reset values: all *_N = 1, SRAM_DQ_OE = 0, SRAM_ADDR = 0, SRAM_DQ_Out = 0, RData = 0, Ready = 0, Busy = 0; state = IDLE.
- Reset asserted in any state: all outputs return to reset values at the next edge. No Ready is issued and the in-flight access is dropped.
- States: IDLE -> SETUP -> ACCESS (WAIT_STATES cycles, down-counter) -> HOLD -> TURN (TURNAROUND cycles, skipped if 0) -> IDLE.
- Cycle numbering: accept edge = cycle 0.
- IDLE: pins inactive, Busy = 0. If Req = 1, latch R_W, Addr and WData; next state is SETUP.
- SETUP (cycle 1): SRAM_ADDR = zero-extended latched address; CE_N = 0; LB_N = UB_N = 0.
  - Read: OE_N = 0.
  - Write: DQ_OE = 1, SRAM_DQ_Out = latched data, WE_N = 1.
- ACCESS (cycles 2..1+W): address, CE and lanes held.
  - Write: WE_N = 0, DQ_OE = 1.
  - Read: OE_N = 0. SRAM_DQ_In is captured into RData on the last ACCESS edge.
- HOLD (cycle 2+W): WE_N = 1, OE_N = 1, CE_N = 0, address held; for writes, DQ_OE = 1 (data hold). Ready = 1 for this cycle only. For reads, RData is valid from this cycle and stays stable until the next read's capture.
- TURN: all pins inactive, DQ_OE = 0, Busy = 1.
- Req outside IDLE is ignored, not queued. A Req held high is re-accepted at the earliest in cycle 3+W+T, i.e. one access per 3+W+T cycles.
- WE_N and OE_N are never low in the same cycle. DQ_OE is never high during a read.
- Writes never modify RData.

Optional Feature:
Macro: SRAM_BYTE_ACCESS_EN.
- Enabled:
  - Adds port ByteEn (in, 1), latched at accept.
  - ByteEn = 1: SRAM_ADDR = Addr >> 1. Addr[0] = 0 drives LB_N low; Addr[0] = 1 drives UB_N low. The other lane strobe stays high.
  - Byte write: WData[DATA_W/2-1:0] is replicated onto both halves of SRAM_DQ_Out.
  - Byte read: RData = the selected half, zero-extended.
  - ByteEn = 0: word access identical to the disabled build.
- Disabled: no ByteEn port; LB_N and UB_N always equal CE_N.

Test Plan:
1. Reset held 3 cycles, then released with Req = 0 -> all *_N = 1, DQ_OE = 0, RData = 0x0000, Ready = 0, Busy = 0.
2. W = 2, T = 1; write Addr = 0x3000, WData = 0xBEEF -> SRAM_ADDR = 0x03000 in cycles 1-4; WE_N low in cycles 2-3 only; DQ_OE high in cycles 1-4 with DQ = 0xBEEF; Ready in cycle 4; Busy high in cycles 1-5.
3. Read Addr = 0x3000 with the SRAM model returning 0xBEEF -> OE_N low in cycles 1-3, Ready in cycle 4 with RData = 0xBEEF, DQ_OE = 0 throughout.
4. Req held high for 2 accesses -> accepts at cycles 0 and 6 only; exactly 2 Ready pulses (cycles 4 and 10).
5. Reset pulsed during cycle 2 of a write -> pins inactive at the next edge, no Ready; a following read of 0x0010 completes normally.
6. SRAM_BYTE_ACCESS_EN: byte write 0x5A to Addr 0x0001 -> SRAM_ADDR = 0x00000, UB_N = 0, LB_N = 1, DQ = 0x5A5A. Byte read of the same address -> RData = 0x005A.
